// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared register map, scan states and hex segment table
package seg_scan_pkg;
  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_DATA = 8'h04;
  localparam logic [7:0] REG_RAW  = 8'h08;
  localparam logic [7:0] REG_DIV  = 8'h0C;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLANK = 1;
  localparam int CTRL_HEX   = 2;
  typedef enum logic [1:0] {IDLE, SHOW, GAP} scan_state_t;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg_scan_ctrl_seg7_decode.sv
// seg7_decode: nibble to segments a..g lookup
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: wishbone-configured multiplexed seven-segment scanner
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int          DIGITS    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] DIV_RESET = 16'd1000,
  parameter int          GUARD     = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic [7+DIGITS-1:0] io_oeb
);
  localparam logic [31:0] DATA_MASK = 32'((64'd1 << (4 * DIGITS)) - 64'd1);
  localparam logic [31:0] RAW_MASK  = 32'h7F7F_7F7F & 32'((64'd1 << (8 * DIGITS)) - 64'd1);
  logic [2:0]        ctrl_r;
  logic [31:0]       data_r, raw_r, rdata, wmask;
  logic [15:0]       div_r, div_lat, cnt, nxt_cnt;
  logic [1:0]        idx, nxt_idx;
  logic [6:0]        seg_lat, dec;
  logic [7:0]        off;
  logic [DIGITS-1:0] sel_oh;
  logic              hit, show_entry;
  scan_state_t       state, nxt_state;
  // Block spans 256 bytes so addresses past DIV still ack and read zero
  assign hit   = wbs_stb_i && wbs_cyc_i && !wbs_ack_o && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off   = wbs_adr_i[7:0];
  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction
  // Read mux with unused bits and offsets returning zero
  always_comb begin
    rdata = (off == REG_CTRL) ? {29'd0, ctrl_r} :
            (off == REG_DATA) ? data_r :
            (off == REG_RAW)  ? raw_r :
            (off == REG_DIV)  ? {16'd0, div_r} : 32'd0;
  end
  // Register file and single-cycle ack; writes commit on the ack edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ctrl_r    <= '0;
      data_r    <= '0;
      raw_r     <= '0;
      div_r     <= DIV_RESET;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit && !wbs_we_i) ? rdata : '0;
      if (hit && wbs_we_i && off == REG_CTRL) ctrl_r <= 3'(merge({29'd0, ctrl_r}, wbs_dat_i, wmask));
      if (hit && wbs_we_i && off == REG_DATA) data_r <= merge(data_r, wbs_dat_i, wmask) & DATA_MASK;
      if (hit && wbs_we_i && off == REG_RAW)  raw_r  <= merge(raw_r, wbs_dat_i, wmask) & RAW_MASK;
      if (hit && wbs_we_i && off == REG_DIV)  div_r  <= 16'(merge({16'd0, div_r}, wbs_dat_i, wmask));
    end
  end
  // Scan next-state: dwell counter, digit wrap, and EN drop to IDLE from anywhere
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    if (!ctrl_r[CTRL_EN]) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else if (state == IDLE) begin
      nxt_state = SHOW;
    end else if (state == SHOW) begin
      nxt_state = (cnt == div_lat - 16'd1) ? GAP : SHOW;
      nxt_cnt   = (cnt == div_lat - 16'd1) ? 16'd0 : cnt + 16'd1;
    end else begin
      nxt_state = (cnt == 16'(GUARD - 1)) ? SHOW : GAP;
      nxt_cnt   = (cnt == 16'(GUARD - 1)) ? 16'd0 : cnt + 16'd1;
      nxt_idx   = (cnt != 16'(GUARD - 1)) ? idx : (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
    end
    show_entry = (nxt_state == SHOW) && (state != SHOW);
    sel_oh     = DIGITS'(1) << idx;
  end
  seg7_decode u_dec (
    .nib (data_r[{nxt_idx, 2'b00} +: 4]),
    .seg (dec)
  );
  // Scan state, dwell counter and digit index
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      idx   <= nxt_idx;
    end
  end
  // Segments and dwell length are frozen at SHOW entry so writes never tear a digit
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      seg_lat <= '0;
      div_lat <= 16'd1;
    end else if (show_entry) begin
      seg_lat <= ctrl_r[CTRL_HEX] ? dec : raw_r[{nxt_idx, 3'b000} +: 7];
      div_lat <= (div_r == 16'd0) ? 16'd1 : div_r;
    end
  end
  // Registered pad outputs, one cycle behind the scan state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      seg_out <= '0;
      dig_sel <= '0;
      io_oeb  <= '1;
    end else begin
      seg_out <= (state == SHOW && !ctrl_r[CTRL_BLANK]) ? seg_lat : '0;
      dig_sel <= (state == SHOW) ? sel_oh : '0;
      io_oeb  <= {(7 + DIGITS){state == IDLE}};
    end
  end
endmodule
